ex_stage: RTL and testbench

- Execute stage of the RV32I 5-stage pipeline. Consumes the E-suffixed outputs of the ID/EX pipeline register.
- Performs ALU operation, branch compare, and branch/jump target computation.
- Drives a one-shot PC redirect toward fetch.
- Registers results into the EX/MEM boundary (M-suffixed outputs) with stall, flush and wrong-path squash.

---
 rtl/ex_stage.sv | 193 +++++++++++++++++++
 tb/tb_ex_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// RV32I execute stage: ALU, branch compare, redirect target, and the EX/MEM register.
// Optional operand forwarding is enabled with `define EX_FWD_EN.
//
// state  | meaning
// -------+-------------------------------------------------------------
// RUN    | instruction in EX is live; a taken branch/jump redirects
// HOLD   | redirect already issued while stalled; EX instruction still live
// SHADOW | instruction in EX is wrong-path; it is captured as a bubble
module ex_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemReadE,
  input  logic            MemWriteE,
  input  logic            RegWriteE,
  input  logic            ALUSrcE,
  input  logic            JumpE,
  input  logic            BranchE,
  input  logic            MuxjalrE,
  input  logic [3:0]      ALUOpE,
  input  logic [2:0]      Funct3E,
  input  logic [2:0]      WriteBackE,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [31:0]     RdE,
`ifdef EX_FWD_EN
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
`endif
  input  logic            StallM,
  input  logic            FlushM,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [4:0]      RdM,
  output logic            MemReadM,
  output logic            MemWriteM,
  output logic            RegWriteM,
  output logic [2:0]      WriteBackM,
  output logic            ValidM
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    SHADOW = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] srca, srcb_reg, srcb;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] jalr_sum;
  logic [4:0]      shamt;
  logic            cond, take, redirect, live;
  logic            eq, lt, ltu;
  logic            unused_rd_hi;

  assign unused_rd_hi = ^RdE[31:5];

`ifdef EX_FWD_EN
  always_comb begin
    case (ForwardAE)
      2'b01:   srca = ResultW;
      2'b10:   srca = ALUResultM;
      default: srca = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   srcb_reg = ResultW;
      2'b10:   srcb_reg = ALUResultM;
      default: srcb_reg = RD2E;
    endcase
  end
`else
  always_comb begin
    srca     = RD1E;
    srcb_reg = RD2E;
  end
`endif

  assign srcb  = ALUSrcE ? ImmExtE : srcb_reg;
  assign shamt = srcb[4:0];

  always_comb begin
    alu_result = srca + srcb;
    case (ALUOpE)
      4'd0:    alu_result = srca + srcb;
      4'd1:    alu_result = srca - srcb;
      4'd2:    alu_result = srca << shamt;
      4'd3:    alu_result = {{(XLEN-1){1'b0}}, $signed(srca) < $signed(srcb)};
      4'd4:    alu_result = {{(XLEN-1){1'b0}}, srca < srcb};
      4'd5:    alu_result = srca ^ srcb;
      4'd6:    alu_result = srca >> shamt;
      4'd7:    alu_result = $unsigned($signed(srca) >>> shamt);
      4'd8:    alu_result = srca | srcb;
      4'd9:    alu_result = srca & srcb;
      4'd10:   alu_result = srcb;
      4'd11:   alu_result = PCE + ImmExtE;
      default: alu_result = srca + srcb;
    endcase
  end

  // Branch compare always uses register operands, never the immediate.
  assign eq  = (srca == srcb_reg);
  assign lt  = ($signed(srca) < $signed(srcb_reg));
  assign ltu = (srca < srcb_reg);

  always_comb begin
    cond = 1'b0;
    case (Funct3E)
      3'b000:  cond = eq;
      3'b001:  cond = ~eq;
      3'b100:  cond = lt;
      3'b101:  cond = ~lt;
      3'b110:  cond = ltu;
      3'b111:  cond = ~ltu;
      default: cond = 1'b0;
    endcase
  end

  assign take      = JumpE | (BranchE & cond);
  assign jalr_sum  = srca + ImmExtE;
  assign PCTargetE = MuxjalrE ? {jalr_sum[XLEN-1:1], 1'b0} : (PCE + ImmExtE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Transitions ignore FlushM so a flushed redirect still shadows its successor.
  always_comb begin
    state_d  = state_q;
    redirect = 1'b0;
    case (state_q)
      RUN: begin
        redirect = take;
        if (take) state_d = StallM ? HOLD : SHADOW;
      end
      HOLD: begin
        if (!StallM) state_d = SHADOW;
      end
      SHADOW: begin
        if (!StallM) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign PCSrcE = redirect & reset;
  assign live   = (state_q != SHADOW);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= RESET_PC;
      RdM        <= '0;
      MemReadM   <= 1'b0;
      MemWriteM  <= 1'b0;
      RegWriteM  <= 1'b0;
      WriteBackM <= '0;
      ValidM     <= 1'b0;
    end else if (FlushM) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RdM        <= '0;
      MemReadM   <= 1'b0;
      MemWriteM  <= 1'b0;
      RegWriteM  <= 1'b0;
      WriteBackM <= '0;
      ValidM     <= 1'b0;
    end else if (!StallM) begin
      ALUResultM <= alu_result;
      WriteDataM <= srcb_reg;
      PCPlus4M   <= PCPlus4E;
      RdM        <= RdE[4:0];
      MemReadM   <= MemReadE & live;
      MemWriteM  <= MemWriteE & live;
      RegWriteM  <= RegWriteE & live;
      WriteBackM <= WriteBackE;
      ValidM     <= live;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: expected EX/MEM contents are queued at drive time
// and compared one cycle later; redirect outputs are checked combinationally.
module tb_ex_stage;

  localparam int          XLEN = 32;
  localparam logic [31:0] RPC  = 32'h0000_0080;

  logic            clk = 1'b0;
  logic            reset;
  logic            MemReadE, MemWriteE, RegWriteE, ALUSrcE, JumpE, BranchE, MuxjalrE;
  logic [3:0]      ALUOpE;
  logic [2:0]      Funct3E, WriteBackE;
  logic [31:0]     RD1E, RD2E, PCE, ImmExtE, PCPlus4E, RdE;
  logic            StallM, FlushM;
  logic            PCSrcE;
  logic [31:0]     PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]      RdM;
  logic            MemReadM, MemWriteM, RegWriteM, ValidM;
  logic [2:0]      WriteBackM;
`ifdef EX_FWD_EN
  logic [1:0]      ForwardAE, ForwardBE;
  logic [31:0]     ResultW;
`endif

  typedef struct {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        mr, mw, rw;
    logic [2:0]  wb;
    logic        v;
  } mexp_t;

  mexp_t sb[$];
  mexp_t last, rst_e;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(XLEN), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .MemReadE(MemReadE), .MemWriteE(MemWriteE), .RegWriteE(RegWriteE),
    .ALUSrcE(ALUSrcE), .JumpE(JumpE), .BranchE(BranchE), .MuxjalrE(MuxjalrE),
    .ALUOpE(ALUOpE), .Funct3E(Funct3E), .WriteBackE(WriteBackE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
    .RdE(RdE),
`ifdef EX_FWD_EN
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
`endif
    .StallM(StallM), .FlushM(FlushM),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .RdM(RdM), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .RegWriteM(RegWriteM),
    .WriteBackM(WriteBackM), .ValidM(ValidM)
  );

  function automatic mexp_t mk(input logic [31:0] alu, input logic [31:0] wd,
                               input logic [31:0] pc4, input logic [4:0] rd,
                               input logic mr, input logic mw, input logic rw,
                               input logic [2:0] wb, input logic v);
    mexp_t e;
    e.alu = alu; e.wd = wd; e.pc4 = pc4; e.rd = rd;
    e.mr = mr; e.mw = mw; e.rw = rw; e.wb = wb; e.v = v;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_m(input string tag, input mexp_t e);
    chk({tag, ".ALUResultM"}, ALUResultM, e.alu);
    chk({tag, ".WriteDataM"}, WriteDataM, e.wd);
    chk({tag, ".PCPlus4M"},   PCPlus4M,   e.pc4);
    chk({tag, ".RdM"},        {27'd0, RdM}, {27'd0, e.rd});
    chk({tag, ".MemReadM"},   {31'd0, MemReadM},  {31'd0, e.mr});
    chk({tag, ".MemWriteM"},  {31'd0, MemWriteM}, {31'd0, e.mw});
    chk({tag, ".RegWriteM"},  {31'd0, RegWriteM}, {31'd0, e.rw});
    chk({tag, ".WriteBackM"}, {29'd0, WriteBackM}, {29'd0, e.wb});
    chk({tag, ".ValidM"},     {31'd0, ValidM},    {31'd0, e.v});
  endtask

  task automatic tick_pop(input string tag);
    mexp_t e;
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      last = e;
      check_m(tag, e);
    end
  endtask

  task automatic tick_hold(input string tag);
    @(posedge clk); #1;
    check_m(tag, last);
  endtask

  task automatic nop_in();
    MemReadE = 0; MemWriteE = 0; RegWriteE = 0; ALUSrcE = 0; JumpE = 0;
    BranchE = 0; MuxjalrE = 0; ALUOpE = 0; Funct3E = 0; WriteBackE = 0;
    RD1E = 0; RD2E = 0; PCE = 0; ImmExtE = 0; PCPlus4E = 0; RdE = 0;
`ifdef EX_FWD_EN
    ForwardAE = 0; ForwardBE = 0; ResultW = 0;
`endif
  endtask

  initial begin
    rst_e = mk(0, 0, RPC, 0, 0, 0, 0, 0, 0);
    nop_in(); StallM = 0; FlushM = 0; reset = 0;
    JumpE = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.PCSrcE", {31'd0, PCSrcE}, 0);
    check_m("reset", rst_e);
    reset = 1;

    // ADD overflow wraps
    nop_in(); RD1E = 32'h7FFF_FFFF; RD2E = 1; RegWriteE = 1; RdE = 32'hFFFF_FFE3;
    PCPlus4E = 4; WriteBackE = 1;
    sb.push_back(mk(32'h8000_0000, 1, 4, 3, 0, 0, 1, 1, 1));
    tick_pop("add");

    // reset asserted while a redirect is held by a stall
    nop_in(); JumpE = 1; PCE = 32'h40; ImmExtE = 8; StallM = 1; #1;
    chk("jal_stall.PCSrcE", {31'd0, PCSrcE}, 1);
    chk("jal_stall.PCTargetE", PCTargetE, 32'h48);
    tick_hold("jal_stall");
    #2 reset = 0; #1;
    check_m("mid_reset", rst_e);
    chk("mid_reset.PCSrcE", {31'd0, PCSrcE}, 0);
    last = rst_e;
    reset = 1; StallM = 0;
    ALUOpE = 10; ALUSrcE = 1; RegWriteE = 1; RdE = 1; PCPlus4E = 32'h44; #1;
    chk("post_reset.PCSrcE", {31'd0, PCSrcE}, 1);
    sb.push_back(mk(8, 0, 32'h44, 1, 0, 0, 1, 0, 1));
    tick_pop("post_reset");
    nop_in(); ALUOpE = 1; RD1E = 10; RD2E = 3; RegWriteE = 1; MemReadE = 1; JumpE = 1;
    RdE = 5; PCPlus4E = 32'h48; WriteBackE = 2; #1;
    chk("shadow1.PCSrcE", {31'd0, PCSrcE}, 0);
    sb.push_back(mk(7, 3, 32'h48, 5, 0, 0, 0, 2, 0));
    tick_pop("shadow1");

    // ALU operations
    nop_in(); ALUOpE = 7; RD1E = 32'h8000_0000; ImmExtE = 4; ALUSrcE = 1; RD2E = 32'h55;
    sb.push_back(mk(32'hF800_0000, 32'h55, 0, 0, 0, 0, 0, 0, 1));
    tick_pop("sra");
    nop_in(); ALUOpE = 4; RD1E = 1; RD2E = 32'hFFFF_FFFF;
    sb.push_back(mk(1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 1));
    tick_pop("sltu");
    nop_in(); ALUOpE = 3; RD1E = 1; RD2E = 32'hFFFF_FFFF;
    sb.push_back(mk(0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 1));
    tick_pop("slt");
    nop_in(); ALUOpE = 2; RD1E = 1; RD2E = 32'h21;
    sb.push_back(mk(2, 32'h21, 0, 0, 0, 0, 0, 0, 1));
    tick_pop("sll");
    nop_in(); ALUOpE = 11; PCE = 32'h1000; ImmExtE = 32'h2000; RD1E = 5; RD2E = 6;
    sb.push_back(mk(32'h3000, 6, 0, 0, 0, 0, 0, 0, 1));
    tick_pop("auipc");
    nop_in(); ALUOpE = 14; RD1E = 32'h10; RD2E = 32'h22;
    sb.push_back(mk(32'h32, 32'h22, 0, 0, 0, 0, 0, 0, 1));
    tick_pop("op14");

    // BEQ taken, then wrong-path bubble
    nop_in(); BranchE = 1; RD1E = 5; RD2E = 5; PCE = 32'h100; ImmExtE = 32'h20;
    ALUOpE = 1; PCPlus4E = 32'h104; #1;
    chk("beq.PCSrcE", {31'd0, PCSrcE}, 1);
    chk("beq.PCTargetE", PCTargetE, 32'h120);
    sb.push_back(mk(0, 5, 32'h104, 0, 0, 0, 0, 0, 1));
    tick_pop("beq");
    nop_in(); RD1E = 2; RD2E = 3; RegWriteE = 1; MemWriteE = 1; RdE = 7; JumpE = 1; #1;
    chk("beq_shadow.PCSrcE", {31'd0, PCSrcE}, 0);
    sb.push_back(mk(5, 3, 0, 7, 0, 0, 0, 0, 0));
    tick_pop("beq_shadow");

    // other branch conditions
    nop_in(); BranchE = 1; Funct3E = 3'b001; RD1E = 9; RD2E = 9; #1;
    chk("bne.PCSrcE", {31'd0, PCSrcE}, 0);
    sb.push_back(mk(32'h12, 9, 0, 0, 0, 0, 0, 0, 1));
    tick_pop("bne");
    nop_in(); BranchE = 1; Funct3E = 3'b100; RD1E = 32'hFFFF_FFFF; RD2E = 1; #1;
    chk("blt.PCSrcE", {31'd0, PCSrcE}, 1);
    sb.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1));
    tick_pop("blt");
    nop_in(); #1;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick_pop("blt_shadow");
    nop_in(); BranchE = 1; Funct3E = 3'b010; #1;
    chk("f3_010.PCSrcE", {31'd0, PCSrcE}, 0);
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    tick_pop("f3_010");
    nop_in(); BranchE = 1; Funct3E = 3'b111; RD1E = 1; RD2E = 32'hFFFF_FFFF; #1;
    chk("bgeu.PCSrcE", {31'd0, PCSrcE}, 0);
    sb.push_back(mk(0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 1));
    tick_pop("bgeu");

    // JALR held by a 3-cycle stall: one redirect only
    nop_in(); JumpE = 1; MuxjalrE = 1; RD1E = 32'h1001; ImmExtE = 2; RegWriteE = 1;
    RdE = 1; PCPlus4E = 32'h204; WriteBackE = 3; StallM = 1; #1;
    chk("jalr.PCSrcE", {31'd0, PCSrcE}, 1);
    chk("jalr.PCTargetE", PCTargetE, 32'h1002);
    tick_hold("jalr_stall1");
    #1 chk("jalr_stall2.PCSrcE", {31'd0, PCSrcE}, 0);
    tick_hold("jalr_stall2");
    #1 chk("jalr_stall3.PCSrcE", {31'd0, PCSrcE}, 0);
    tick_hold("jalr_stall3");
    StallM = 0; #1;
    chk("jalr_go.PCSrcE", {31'd0, PCSrcE}, 0);
    sb.push_back(mk(32'h1001, 0, 32'h204, 1, 0, 0, 1, 3, 1));
    tick_pop("jalr");
    nop_in(); RD1E = 4; RD2E = 4; BranchE = 1; StallM = 1; #1;
    chk("jalr_shadow_stall.PCSrcE", {31'd0, PCSrcE}, 0);
    tick_hold("jalr_shadow_stall");
    StallM = 0; #1;
    chk("jalr_shadow.PCSrcE", {31'd0, PCSrcE}, 0);
    sb.push_back(mk(8, 4, 0, 0, 0, 0, 0, 0, 0));
    tick_pop("jalr_shadow");

    // flush wins over stall on a live store
    nop_in(); MemWriteE = 1; RD1E = 32'h10; ImmExtE = 4; ALUSrcE = 1; RD2E = 32'hDEAD;
    StallM = 1; FlushM = 1;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick_pop("flush_stall");
    StallM = 0; FlushM = 0;

`ifdef EX_FWD_EN
    nop_in(); RD1E = 4; RD2E = 5;
    sb.push_back(mk(9, 5, 0, 0, 0, 0, 0, 0, 1));
    tick_pop("fwd_pre");
    nop_in(); ForwardAE = 2'b10; RD1E = 32'h77; ALUSrcE = 1; ImmExtE = 1;
    sb.push_back(mk(32'hA, 0, 0, 0, 0, 0, 0, 0, 1));
    tick_pop("fwd_a_mem");
    nop_in(); ForwardBE = 2'b01; ResultW = 32'hAB; MemWriteE = 1; RD2E = 32'h11;
    ALUSrcE = 1; ImmExtE = 4;
    sb.push_back(mk(4, 32'hAB, 0, 0, 0, 1, 0, 0, 1));
    tick_pop("fwd_b_wb");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
